// File: rtl/io_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the IO pad register file.
// Optional bus-cycle timeout with error termination is enabled by defining IO_ARB_TIMEOUT_EN.
module io_wb_arbiter #(
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_wb_cyc_i,
  input  logic [1:0]             m_wb_stb_i,
  input  logic [1:0]             m_wb_we_i,
  input  logic [2*DAT_W/8-1:0]   m_wb_sel_i,
  input  logic [2*ADR_W-1:0]     m_wb_adr_i,
  input  logic [2*DAT_W-1:0]     m_wb_dat_i,
  output logic [2*DAT_W-1:0]     m_wb_dat_o,
  output logic [1:0]             m_wb_ack_o,
  output logic [1:0]             m_wb_err_o,
  output logic                   s_wb_cyc_o,
  output logic                   s_wb_stb_o,
  output logic                   s_wb_we_o,
  output logic [DAT_W/8-1:0]     s_wb_sel_o,
  output logic [ADR_W-1:0]       s_wb_adr_o,
  output logic [DAT_W-1:0]       s_wb_dat_o,
  input  logic [DAT_W-1:0]       s_wb_dat_i,
  input  logic                   s_wb_ack_i,
  output logic [1:0]             arb_gnt_o
);

  localparam int SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state;
  logic       last;
  logic [1:0] gnt_q;
  logic       timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("io_wb_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that was not served last wins.
          if (m_wb_cyc_i[0] && (!m_wb_cyc_i[1] || last)) begin
            state <= GNT0;
            last  <= 1'b0;
            gnt_q <= 2'b01;
          end else if (m_wb_cyc_i[1]) begin
            state <= GNT1;
            last  <= 1'b1;
            gnt_q <= 2'b10;
          end
        end
        GNT0: begin
          if (!m_wb_cyc_i[0] || timeout_hit) begin
            state <= IDLE;
            gnt_q <= 2'b00;
          end
        end
        GNT1: begin
          if (!m_wb_cyc_i[1] || timeout_hit) begin
            state <= IDLE;
            gnt_q <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= 2'b00;
        end
      endcase
    end
  end

  assign arb_gnt_o = gnt_q;

  // NOTE: every output gets a default first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_sel_o = '0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    m_wb_ack_o = 2'b00;
    m_wb_dat_o = '0;
    case (state)
      GNT0: begin
        s_wb_cyc_o              = m_wb_cyc_i[0];
        s_wb_stb_o              = m_wb_stb_i[0];
        s_wb_we_o               = m_wb_we_i[0];
        s_wb_sel_o              = m_wb_sel_i[0 +: SEL_W];
        s_wb_adr_o              = m_wb_adr_i[0 +: ADR_W];
        s_wb_dat_o              = m_wb_dat_i[0 +: DAT_W];
        m_wb_ack_o[0]           = s_wb_ack_i;
        m_wb_dat_o[0 +: DAT_W]  = s_wb_dat_i;
      end
      GNT1: begin
        s_wb_cyc_o                  = m_wb_cyc_i[1];
        s_wb_stb_o                  = m_wb_stb_i[1];
        s_wb_we_o                   = m_wb_we_i[1];
        s_wb_sel_o                  = m_wb_sel_i[SEL_W +: SEL_W];
        s_wb_adr_o                  = m_wb_adr_i[ADR_W +: ADR_W];
        s_wb_dat_o                  = m_wb_dat_i[DAT_W +: DAT_W];
        m_wb_ack_o[1]               = s_wb_ack_i;
        m_wb_dat_o[DAT_W +: DAT_W]  = s_wb_dat_i;
      end
      default: ;
    endcase
  end

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // An ack in the same cycle as the limit completes the transfer normally.
  assign timeout_hit = (state != IDLE) && !s_wb_ack_i &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign m_wb_err_o  = {timeout_hit && (state == GNT1),
                        timeout_hit && (state == GNT0)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || s_wb_ack_i || timeout_hit) begin
      tmo_cnt <= '0;
    end else if (s_wb_cyc_o) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign m_wb_err_o  = 2'b00;
`endif

endmodule

// File: tb/tb_io_wb_arbiter.sv
// Directed self-checking bench for io_wb_arbiter: reset, latency, round-robin,
// stall of the ungranted master, dropped acks and hold / timeout behaviour.
module tb_io_wb_arbiter;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W / 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           m_cyc = '0;
  logic [1:0]           m_stb = '0;
  logic [1:0]           m_we  = '0;
  logic [2*SEL_W-1:0]   m_sel = '0;
  logic [2*ADR_W-1:0]   m_adr = '0;
  logic [2*DAT_W-1:0]   m_wdat = '0;
  logic [2*DAT_W-1:0]   m_rdat;
  logic [1:0]           m_ack;
  logic [1:0]           m_err;
  logic                 s_cyc;
  logic                 s_stb;
  logic                 s_we;
  logic [SEL_W-1:0]     s_sel;
  logic [ADR_W-1:0]     s_adr;
  logic [DAT_W-1:0]     s_wdat;
  logic [DAT_W-1:0]     s_rdat = '0;
  logic                 s_ack = 1'b0;
  logic [1:0]           gnt;

  int errors = 0;
  int checks = 0;

  io_wb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_wb_cyc_i (m_cyc),
    .m_wb_stb_i (m_stb),
    .m_wb_we_i  (m_we),
    .m_wb_sel_i (m_sel),
    .m_wb_adr_i (m_adr),
    .m_wb_dat_i (m_wdat),
    .m_wb_dat_o (m_rdat),
    .m_wb_ack_o (m_ack),
    .m_wb_err_o (m_err),
    .s_wb_cyc_o (s_cyc),
    .s_wb_stb_o (s_stb),
    .s_wb_we_o  (s_we),
    .s_wb_sel_o (s_sel),
    .s_wb_adr_o (s_adr),
    .s_wb_dat_o (s_wdat),
    .s_wb_dat_i (s_rdat),
    .s_wb_ack_i (s_ack),
    .arb_gnt_o  (gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] all_outs();
    return {115'd0, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat, m_ack, m_err, gnt, m_rdat};
  endfunction

  // One tied request: both masters want the bus, the expected one gets a single transfer.
  task automatic rr_xfer(input int idx, input logic [DAT_W-1:0] pat);
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    #1;
    check("rr_idle_gnt", gnt, 2'b00);
    tick();
    #1;
    check("rr_gnt", gnt, oh);
    check("rr_adr", s_adr, (idx == 1) ? 32'h0000_0010 : 32'h0000_0004);
    tick();
    s_ack  = 1'b1;
    s_rdat = pat;
    #1;
    check("rr_ack", m_ack, oh);
    check("rr_dat", m_rdat, (idx == 1) ? {pat, 32'h0} : {32'h0, pat});
    tick();
    s_ack      = 1'b0;
    s_rdat     = '0;
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
    #1;
    check("rr_release_cyc", s_cyc, 1'b0);
    check("rr_release_ack", m_ack, 2'b00);
    tick();
  endtask

  initial begin
    m_adr  = {32'h0000_0010, 32'h0000_0004};
    m_wdat = {32'h0000_0005, 32'hAAAA_0000};
    m_sel  = {4'b0001, 4'b1111};
    m_we   = 2'b10;

    // Reset state
    tick();
    tick();
    check("reset_outs", all_outs(), 256'd0);
    rst = 1'b0;

    // Master 1 alone, then reset mid-transfer
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #1;
    check("m1_req_idle", gnt, 2'b00);
    tick();
    #1;
    check("m1_gnt", gnt, 2'b10);
    check("m1_slave_we", {s_cyc, s_we, s_adr}, {1'b1, 1'b1, 32'h0000_0010});
    rst   = 1'b1;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    #1;
    check("reset_mid_gnt1", all_outs(), 256'd0);
    tick();
    check("reset_held", all_outs(), 256'd0);
    rst = 1'b0;
    m_we = 2'b00;

    // Round robin after reset: m0 wins the first tie
    rr_xfer(0, 32'h1111_0000);
    rr_xfer(1, 32'h2222_0001);
    rr_xfer(0, 32'h3333_0002);
    rr_xfer(1, 32'h4444_0003);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // m0 read of 0x0004 with 2-cycle latency to the ack
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #1;
    check("rd_cycle_n_scyc", s_cyc, 1'b0);
    tick();
    #1;
    check("rd_n1_slave", {s_cyc, s_stb, s_we, s_adr}, {1'b1, 1'b1, 1'b0, 32'h0000_0004});
    tick();
    s_ack  = 1'b1;
    s_rdat = 32'h000F_00FF;
    #1;
    check("rd_n2_ack", m_ack, 2'b01);
    check("rd_n2_dat", m_rdat, {32'h0, 32'h000F_00FF});
    tick();
    s_ack  = 1'b0;
    s_rdat = '0;
    m_cyc  = 2'b00;
    m_stb  = 2'b00;
    #1;
    check("rd_no_extra_ack", m_ack, 2'b00);
    tick();
    #1;
    check("rd_back_idle", gnt, 2'b00);

    // m1 write stalls while m0 holds the grant
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    m_we  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_hold", {gnt, s_we, s_adr}, {2'b01, 1'b0, 32'h0000_0004});
      tick();
    end
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #1;
    check("stall_release", {gnt, s_cyc}, {2'b01, 1'b0});
    tick();
    s_ack = 1'b1;
    #1;
    check("stall_idle_bubble", {gnt, s_cyc, s_we}, {2'b00, 1'b0, 1'b0});
    check("idle_ack_dropped", m_ack, 2'b00);
    tick();
    s_ack = 1'b0;
    #1;
    check("stall_m1_write", {gnt, s_cyc, s_we, s_sel, s_wdat}, {2'b10, 1'b1, 1'b1, 4'b0001, 32'h0000_0005});
    check("ungranted_m0_ack", m_ack, 2'b00);
    tick();
    s_ack = 1'b1;
    #1;
    check("m1_write_ack", m_ack, 2'b10);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    m_we  = 2'b00;
    tick();
    tick();

    // Slave never acks: timeout termination or indefinite hold
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
`ifdef IO_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      #1;
      check("tmo_no_err_yet", {m_err, gnt}, {2'b00, 2'b01});
    end
    tick();
    #1;
    check("tmo_err_pulse", {m_err, m_ack}, {2'b01, 2'b00});
    tick();
    #1;
    check("tmo_bus_idle", {gnt, s_cyc, m_err}, {2'b00, 1'b0, 2'b00});
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      check("hold_no_err", {m_err, gnt}, {2'b00, 2'b01});
    end
`endif
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
